// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, req/gnt/rvalid imem port, 2-entry prefetch FIFO, IF/ID register.
// Optional FETCH_BYPASS_EN loads a response straight into IF/ID when the FIFO is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stallf,
  input  logic        stalld,
  input  logic        flushd,
  input  logic        pcsrce,
  input  logic [31:0] pctargete,
  output logic        imemreq,
  output logic [31:0] imemaddr,
  input  logic        imemgnt,
  input  logic        imemrvalid,
  input  logic [31:0] imemrdata,
  output logic [31:0] instrd,
  output logic [31:0] pcd,
  output logic [31:0] pcplus4d,
  output logic        validd
);

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  logic [31:0] r_pcf;
  logic [2:0]  r_out;
  logic [2:0]  r_kill;
  logic [31:0] r_tag [3];
  logic [1:0]  r_tag_wr;
  logic [1:0]  r_tag_rd;
  logic [31:0] r_fifo_pc [2];
  logic [31:0] r_fifo_instr [2];
  logic        r_fifo_wr;
  logic        r_fifo_rd;
  logic [1:0]  r_cnt;
  logic [31:0] r_instrd;
  logic [31:0] r_pcd;
  logic [31:0] r_pcplus4d;
  logic        r_validd;

  logic [2:0]  w_live;
  logic [3:0]  w_credit;
  logic        w_grant;
  logic        w_rsp;
  logic        w_rsp_keep;
  logic        w_pop;
  logic        w_bypass;
  logic        w_push;
  logic [2:0]  w_out_next;
  logic [31:0] w_rsp_pc;

  function automatic logic [1:0] tag_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts only live (non-killed) requests plus words already buffered.
  assign w_live     = r_out - r_kill;
  assign w_credit   = {1'b0, w_live} + {2'b00, r_cnt};
  assign imemreq    = rstn && !stallf && !pcsrce && (w_credit < 4'd2) && (r_out < 3'd3);
  assign imemaddr   = r_pcf;
  assign w_grant    = imemreq && imemgnt;
  assign w_rsp      = imemrvalid && (r_out != 3'd0);
  assign w_rsp_keep = w_rsp && (r_kill == 3'd0) && !pcsrce;
  assign w_pop      = !stalld && !flushd && (r_cnt != 2'd0);
`ifdef FETCH_BYPASS_EN
  assign w_bypass   = w_rsp_keep && (r_cnt == 2'd0) && !stalld && !flushd;
`else
  assign w_bypass   = 1'b0;
`endif
  assign w_push     = w_rsp_keep && !w_bypass;
  assign w_out_next = r_out + {2'b00, w_grant} - {2'b00, w_rsp};
  assign w_rsp_pc   = r_tag[r_tag_rd];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pcf      <= RESET_PC;
      r_out      <= 3'd0;
      r_kill     <= 3'd0;
      r_tag_wr   <= 2'd0;
      r_tag_rd   <= 2'd0;
      r_fifo_wr  <= 1'b0;
      r_fifo_rd  <= 1'b0;
      r_cnt      <= 2'd0;
      r_validd   <= 1'b0;
      r_instrd   <= NopInstr;
      r_pcd      <= 32'd0;
      r_pcplus4d <= 32'd0;
    end else begin
      r_out <= w_out_next;
      if (w_grant) r_tag_wr <= tag_inc(r_tag_wr);
      if (w_rsp)   r_tag_rd <= tag_inc(r_tag_rd);
      if (pcsrce) begin
        // Everything still outstanding after this edge belongs to the wrong path.
        r_pcf     <= pctargete;
        r_kill    <= w_out_next;
        r_cnt     <= 2'd0;
        r_fifo_wr <= 1'b0;
        r_fifo_rd <= 1'b0;
      end else begin
        if (w_grant) r_pcf <= r_pcf + 32'd4;
        if (w_rsp && (r_kill != 3'd0)) r_kill <= r_kill - 3'd1;
        r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        if (w_push) r_fifo_wr <= ~r_fifo_wr;
        if (w_pop)  r_fifo_rd <= ~r_fifo_rd;
      end
      if (flushd) begin
        r_validd <= 1'b0;
        r_instrd <= NopInstr;
      end else if (!stalld) begin
        if (r_cnt != 2'd0) begin
          r_validd   <= 1'b1;
          r_instrd   <= r_fifo_instr[r_fifo_rd];
          r_pcd      <= r_fifo_pc[r_fifo_rd];
          r_pcplus4d <= r_fifo_pc[r_fifo_rd] + 32'd4;
        end else if (w_bypass) begin
          r_validd   <= 1'b1;
          r_instrd   <= imemrdata;
          r_pcd      <= w_rsp_pc;
          r_pcplus4d <= w_rsp_pc + 32'd4;
        end else begin
          r_validd <= 1'b0;
          r_instrd <= NopInstr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) r_tag[r_tag_wr] <= r_pcf;
    if (w_push) begin
      r_fifo_pc[r_fifo_wr]    <= w_rsp_pc;
      r_fifo_instr[r_fifo_wr] <= imemrdata;
    end
  end

  assign instrd   = r_instrd;
  assign pcd      = r_pcd;
  assign pcplus4d = r_pcplus4d;
  assign validd   = r_validd;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model and an in-order memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stallf = 1'b0, stalld = 1'b0, flushd = 1'b0, pcsrce = 1'b0;
  logic [31:0] pctargete = 32'd0;
  logic        imemreq;
  logic [31:0] imemaddr;
  logic        imemgnt = 1'b0, imemrvalid = 1'b0;
  logic [31:0] imemrdata = 32'd0;
  logic [31:0] instrd, pcd, pcplus4d;
  logic        validd;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn), .stallf(stallf), .stalld(stalld), .flushd(flushd),
    .pcsrce(pcsrce), .pctargete(pctargete), .imemreq(imemreq), .imemaddr(imemaddr),
    .imemgnt(imemgnt), .imemrvalid(imemrvalid), .imemrdata(imemrdata), .instrd(instrd),
    .pcd(pcd), .pcplus4d(pcplus4d), .validd(validd)
  );

  always #5 clk = ~clk;

`ifdef FETCH_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif
  localparam logic [31:0] Nop = 32'h0000_0013;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Memory: in-order queue of accepted requests, each ready mem_lat cycles after its grant.
  typedef struct {logic [31:0] addr; int rdy;} mreq_t;
  mreq_t mem_q[$];
  int mem_lat = 1, gnt_pct = 100, rv_pct = 100;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
  endfunction

  // Reference model.
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  logic [31:0] m_pcf;
  int          m_out, m_kill;
  logic [31:0] m_tags[$];
  ent_t        m_fifo[$];
  logic        m_validd;
  logic [31:0] m_instrd, m_pcd, m_pcplus4d;

  logic        e_req, o_req, o_gnt, o_rv;
  logic [31:0] e_addr, o_addr;

  task automatic model_reset();
    m_pcf = 32'd0; m_out = 0; m_kill = 0;
    m_tags.delete(); m_fifo.delete();
    m_validd = 1'b0; m_instrd = Nop; m_pcd = 32'd0; m_pcplus4d = 32'd0;
    mem_q.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    stallf = 1'b0; stalld = 1'b0; flushd = 1'b0; pcsrce = 1'b0;
    imemrvalid = 1'b0; imemgnt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Advance one clock: drive memory, sample the request, clock, then update the model.
  task automatic step();
    logic        rv, keep, g;
    logic [31:0] rpc;
    logic [31:0] rdata;
    rpc = 32'd0;
    imemgnt = ($urandom_range(99) < gnt_pct);
    rv = (mem_q.size() > 0) && (mem_q[0].rdy <= cyc) && ($urandom_range(99) < rv_pct);
    imemrvalid = rv;
    imemrdata = rv ? mem_word(mem_q[0].addr) : $urandom;
    rdata = imemrdata;
    e_req = !stallf && !pcsrce && (m_out - m_kill + m_fifo.size() < 2) && (m_out < 3);
    e_addr = m_pcf;
    #1;
    o_req = imemreq; o_addr = imemaddr; o_gnt = imemgnt; o_rv = rv;
    if (rv) begin
      tests++;
      if (m_out == 0) begin
        fails++;
        $display("FAIL protocol: rvalid with %0d outstanding, required >0", m_out);
      end
    end
    @(posedge clk);
    cyc++;
    if (rv) void'(mem_q.pop_front());
    if (o_req && o_gnt) mem_q.push_back('{o_addr, cyc - 1 + mem_lat});
    g = e_req && o_gnt;
    keep = 1'b0;
    if (rv && m_tags.size() > 0) begin
      rpc = m_tags.pop_front();
      m_out--;
      if (m_kill > 0) m_kill--;
      else if (!pcsrce) keep = 1'b1;
    end
    if (flushd) begin
      m_validd = 1'b0; m_instrd = Nop;
    end else if (!stalld) begin
      if (m_fifo.size() > 0) begin
        ent_t h;
        h = m_fifo.pop_front();
        m_validd = 1'b1; m_instrd = h.instr; m_pcd = h.pc; m_pcplus4d = h.pc + 32'd4;
      end else if (Bypass && keep) begin
        m_validd = 1'b1; m_instrd = rdata; m_pcd = rpc; m_pcplus4d = rpc + 32'd4;
        keep = 1'b0;
      end else begin
        m_validd = 1'b0; m_instrd = Nop;
      end
    end
    if (keep) m_fifo.push_back('{rpc, rdata});
    if (pcsrce) begin
      m_fifo.delete();
      m_pcf = pctargete;
      m_kill = m_out;
    end else if (g) begin
      m_tags.push_back(m_pcf);
      m_pcf += 32'd4;
      m_out++;
    end
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    tests++;
    if (imemreq !== 1'b0) begin fails++; $display("FAIL reset_req: got %b need 0", imemreq); end
    @(negedge clk);
    tests++;
    if ({validd, instrd, pcd, pcplus4d} !== {1'b0, Nop, 32'd0, 32'd0}) begin
      fails++;
      $display("FAIL reset_ifid: got %b %h %h %h need 0 00000013 0 0", validd, instrd, pcd, pcplus4d);
    end
    do_reset();
    #1;
    tests++;
    if (imemreq !== 1'b1 || imemaddr !== 32'd0) begin
      fails++; $display("FAIL reset_first_req: got %b %h need 1 00000000", imemreq, imemaddr);
    end
    // Asynchronous reset in mid-operation clears state without a clock edge.
    mem_lat = 1; gnt_pct = 100; rv_pct = 100;
    repeat (8) step();
    #2 rstn = 1'b0;
    #1;
    tests++;
    if ({imemreq, validd, pcd, pcplus4d, instrd} !== {1'b0, 1'b0, 32'd0, 32'd0, Nop}) begin
      fails++;
      $display("FAIL async_reset: got %b %b %h %h %h need 0 0 0 0 00000013",
               imemreq, validd, pcd, pcplus4d, instrd);
    end
  endtask

  task automatic test_single_cycle_mem();
    logic [31:0] addrs[$];
    logic [31:0] last;
    bit          seen;
    do_reset();
    mem_lat = 1; gnt_pct = 100; rv_pct = 100;
    seen = 1'b0; last = 32'd0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (o_req && o_gnt) addrs.push_back(o_addr);
      if (i == (Bypass ? 2 : 3)) begin
        tests++;
        if (validd !== 1'b1 || pcd !== 32'd0) begin
          fails++; $display("FAIL first_decode: got v=%b pc=%h need v=1 pc=0", validd, pcd);
        end
      end
      if (validd === 1'b1) begin
        tests++;
        if ((seen && pcd !== last + 32'd4) || instrd !== mem_word(pcd)
            || pcplus4d !== pcd + 32'd4) begin
          fails++;
          $display("FAIL seq_decode: got pc=%h ins=%h p4=%h need pc=%h", pcd, instrd, pcplus4d,
                   seen ? last + 32'd4 : 32'd0);
        end
        seen = 1'b1; last = pcd;
      end
    end
    tests++;
    if (addrs.size() < 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
      fails++; $display("FAIL req_order: got %0d grants, need 0x0,0x4,0x8 first", addrs.size());
    end
  endtask

  task automatic test_stalld();
    logic [31:0] snap_pc, snap_ins, last;
    logic        snap_v;
    int          nvalid;
    do_reset();
    mem_lat = 2; gnt_pct = 100; rv_pct = 100;
    last = 32'hFFFF_FFFC; nvalid = 0;
    repeat (8) begin
      step();
      if (validd === 1'b1) begin last = pcd; nvalid++; end
    end
    snap_pc = pcd; snap_ins = instrd; snap_v = validd;
    stalld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if ({validd, pcd, instrd} !== {snap_v, snap_pc, snap_ins}) begin
        fails++; $display("FAIL stall_hold: got %b %h %h need %b %h %h",
                          validd, pcd, instrd, snap_v, snap_pc, snap_ins);
      end
    end
    tests++;
    if (o_req !== 1'b0) begin fails++; $display("FAIL stall_req_drop: got %b need 0", o_req); end
    stalld = 1'b0;
    repeat (16) begin
      step();
      if (validd === 1'b1) begin
        tests++;
        if (pcd !== last + 32'd4 || instrd !== mem_word(pcd)) begin
          fails++; $display("FAIL stall_resume: got pc=%h ins=%h need pc=%h", pcd, instrd, last + 4);
        end
        last = pcd; nvalid++;
      end
    end
    tests++;
    if (nvalid < 10) begin fails++; $display("FAIL stall_count: got %0d decodes need >=10", nvalid); end
  endtask

  task automatic test_redirect();
    bit found;
    int guard;
    do_reset();
    mem_lat = 3; gnt_pct = 100; rv_pct = 100;
    guard = 0;
    while (m_out != 2 && guard < 20) begin step(); guard++; end
    tests++;
    if (m_out != 2) begin fails++; $display("FAIL redir_setup: got %0d in flight need 2", m_out); end
    pcsrce = 1'b1; flushd = 1'b1; pctargete = 32'h100;
    step();
    tests++;
    if (o_req !== 1'b0) begin fails++; $display("FAIL redir_noreq: got %b need 0", o_req); end
    pcsrce = 1'b0; flushd = 1'b0;
    step();
    tests++;
    if (o_req !== 1'b1 || o_addr !== 32'h100) begin
      fails++; $display("FAIL redir_target: got %b %h need 1 00000100", o_req, o_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 15 && !found; i++) begin
      step();
      if (validd === 1'b1) begin
        found = 1'b1;
        tests++;
        if (pcd !== 32'h100 || instrd !== mem_word(32'h100)) begin
          fails++; $display("FAIL redir_first: got pc=%h ins=%h need pc=00000100", pcd, instrd);
        end
      end
    end
    tests++;
    if (!found) begin fails++; $display("FAIL redir_timeout: got no valid decode need pc=00000100"); end
  endtask

  task automatic test_redirect_coincident();
    int  guard;
    bit  found;
    do_reset();
    mem_lat = 1; gnt_pct = 100; rv_pct = 100;
    repeat (5) step();
    guard = 0;
    while (!(mem_q.size() > 0 && mem_q[0].rdy <= cyc) && guard < 10) begin step(); guard++; end
    pcsrce = 1'b1; flushd = 1'b1; pctargete = 32'h200;
    step();
    tests++;
    if (o_req !== 1'b0 || o_rv !== 1'b1) begin
      fails++; $display("FAIL coinc_setup: got req=%b rv=%b need req=0 rv=1", o_req, o_rv);
    end
    pcsrce = 1'b0; flushd = 1'b0;
    step();
    tests++;
    if (validd !== 1'b0 || instrd !== Nop || o_addr !== 32'h200) begin
      fails++; $display("FAIL coinc_empty: got v=%b ins=%h addr=%h need 0 00000013 00000200",
                        validd, instrd, o_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (validd === 1'b1) begin
        found = 1'b1;
        tests++;
        if (pcd !== 32'h200) begin fails++; $display("FAIL coinc_first: got %h need 00000200", pcd); end
      end
    end
    tests++;
    if (!found) begin fails++; $display("FAIL coinc_timeout: got no valid decode need 00000200"); end
  endtask

  task automatic test_flush_stall();
    logic [31:0] snap_pc, snap_p4;
    do_reset();
    mem_lat = 1; gnt_pct = 100; rv_pct = 100;
    repeat (6) step();
    snap_pc = pcd; snap_p4 = pcplus4d;
    stalld = 1'b1; flushd = 1'b1;
    step();
    tests++;
    if ({validd, instrd, pcd, pcplus4d} !== {1'b0, Nop, snap_pc, snap_p4}) begin
      fails++; $display("FAIL flush_stall: got %b %h %h %h need 0 00000013 %h %h",
                        validd, instrd, pcd, pcplus4d, snap_pc, snap_p4);
    end
    stalld = 1'b0; flushd = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    gnt_pct = 70; rv_pct = 70;
    for (int i = 0; i < 600; i++) begin
      mem_lat = $urandom_range(1, 3);
      stallf = ($urandom_range(99) < 20);
      stalld = ($urandom_range(99) < 20);
      pcsrce = ($urandom_range(99) < 6);
      flushd = pcsrce ? ($urandom_range(99) < 80) : ($urandom_range(99) < 4);
      pctargete = 32'($urandom_range(0, 1023)) << 2;
      step();
      tests++;
      if (o_req !== e_req || (e_req && o_addr !== e_addr)) begin
        fails++; $display("FAIL rand_req cyc %0d: got %b %h need %b %h", cyc, o_req, o_addr,
                          e_req, e_addr);
      end
      tests++;
      if ({validd, instrd} !== {m_validd, m_instrd}) begin
        fails++; $display("FAIL rand_ifid cyc %0d: got %b %h need %b %h", cyc, validd, instrd,
                          m_validd, m_instrd);
      end
      tests++;
      if (pcd !== m_pcd || pcplus4d !== m_pcplus4d) begin
        fails++; $display("FAIL rand_pc cyc %0d: got %h %h need %h %h", cyc, pcd, pcplus4d,
                          m_pcd, m_pcplus4d);
      end
    end
    stallf = 1'b0; stalld = 1'b0; pcsrce = 1'b0; flushd = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_cycle_mem();
    test_stalld();
    test_redirect();
    test_redirect_coincident();
    test_flush_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
